// File: rtl/prefetch_pkg.sv
// Shared channel indices, state encodings and the round-robin pick used by
// the three-channel prefetch buffer controller.
package prefetch_pkg;

  localparam int unsigned NUM_CH     = 3;
  localparam int unsigned CH_FIR     = 2;
  localparam int unsigned CH_QS      = 1;
  localparam int unsigned CH_MM      = 0;
  localparam int unsigned DEPTH      = 8;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_WAIT_GNT,
    CH_FILL,
    CH_RESP
  } ch_state_e;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_e;

  // Rotation order is FIR -> QS -> MM -> FIR, starting after the last grant.
  function automatic logic [2:0] rr_pick(input logic [1:0] last, input logic [2:0] pend);
    logic [2:0] g;
    g = '0;
    case (last)
      2'd2: begin
        if (pend[1])      g = 3'b010;
        else if (pend[0]) g = 3'b001;
        else if (pend[2]) g = 3'b100;
      end
      2'd1: begin
        if (pend[0])      g = 3'b001;
        else if (pend[2]) g = 3'b100;
        else if (pend[1]) g = 3'b010;
      end
      default: begin
        if (pend[2])      g = 3'b100;
        else if (pend[1]) g = 3'b010;
        else if (pend[0]) g = 3'b001;
      end
    endcase
    return g;
  endfunction

endpackage

// File: rtl/prefetch_chan_ctrl.sv
// One prefetch buffer channel: hit/miss detection, occupancy count, head
// address, burst fill write index and full/empty flags.
module prefetch_chan_ctrl
  import prefetch_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned BURST_LEN   = 8,
  parameter int unsigned PREFETCH_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              gnt_i,
  input  logic              ack_i,
  output logic              wait_o,
  output logic              last_o,
  output logic              hit_o,
  output logic              rsp_o,
  output logic [ADDR_W-1:0] head_o,
  output logic [3:0]        mis_index_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam logic [3:0] LAST_IDX = 4'(BURST_LEN - 1);

  ch_state_e         state_q;
  logic [3:0]        count_q;
  logic [3:0]        idx_q;
  logic [ADDR_W-1:0] head_q;
  logic              hit_q;
  logic              rsp_q;
  logic              full_q;
  logic              empty_q;
  logic              match;

  assign match       = (count_q != '0) && (addr_i == head_q);
  assign wait_o      = (state_q == CH_WAIT_GNT);
  assign last_o      = (state_q == CH_FILL) && ack_i && (idx_q == LAST_IDX);
  assign hit_o       = hit_q;
  assign rsp_o       = rsp_q;
  assign head_o      = head_q;
  assign mis_index_o = idx_q;
  assign full_o      = full_q;
  assign empty_o     = empty_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CH_IDLE;
      count_q <= '0;
      idx_q   <= '0;
      head_q  <= '0;
      hit_q   <= 1'b0;
      rsp_q   <= 1'b0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      hit_q   <= 1'b0;
      rsp_q   <= 1'b0;
      full_q  <= (count_q == 4'(DEPTH));
      empty_q <= (count_q == '0);
      case (state_q)
        // The request is still held during the rsp_valid cycle; ignore it then.
        CH_IDLE: begin
          if (req_i && !rsp_q) begin
            if (match) begin
              hit_q   <= 1'b1;
              count_q <= count_q - 4'd1;
              head_q  <= head_q + ADDR_W'(WORD_BYTES);
              state_q <= CH_RESP;
            end else begin
              count_q <= '0;
              head_q  <= addr_i;
              state_q <= CH_WAIT_GNT;
            end
          end
        end
        CH_WAIT_GNT: begin
          if (gnt_i) state_q <= CH_FILL;
        end
        CH_FILL: begin
          if (ack_i) begin
            count_q <= count_q + 4'd1;
            if (idx_q == LAST_IDX) begin
              idx_q   <= '0;
              state_q <= CH_IDLE;
            end else begin
              idx_q <= idx_q + 4'd1;
            end
          end
        end
        CH_RESP: begin
          rsp_q <= 1'b1;
          if ((PREFETCH_EN != 0) && (count_q == '0)) state_q <= CH_WAIT_GNT;
          else                                       state_q <= CH_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/prefetch_ctrl.sv
// Prefetch buffer controller top: three channel controllers plus the
// round-robin SDRAM burst arbiter and address mux.
module prefetch_ctrl
  import prefetch_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned BURST_LEN   = 8,
  parameter int unsigned PREFETCH_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        req,
  input  logic [ADDR_W-1:0] fir_addr,
  input  logic [ADDR_W-1:0] qs_addr,
  input  logic [ADDR_W-1:0] mm_addr,
  output logic [2:0]        rsp_valid,
  output logic              sd_req,
  output logic [ADDR_W-1:0] sd_addr,
  input  logic              sd_ack,
  output logic [2:0]        burst_req,
  output logic [2:0]        f_ack,
  output logic [2:0]        HIT,
  output logic [3:0]        mis_index_FIR,
  output logic [3:0]        mis_index_QS,
  output logic [3:0]        mis_index_MM,
  output logic [5:0]        state_reg
);

  arb_state_e        arb_q;
  logic [2:0]        gnt_q;
  logic              sd_req_q;
  logic [ADDR_W-1:0] sd_addr_q;
  logic [1:0]        last_q;

  logic [2:0]        wait_v, last_v, hit_v, rsp_v, full_v, empty_v, pick;
  logic [ADDR_W-1:0] addr_a [NUM_CH];
  logic [ADDR_W-1:0] head_a [NUM_CH];
  logic [3:0]        idx_a  [NUM_CH];
  logic [ADDR_W-1:0] sel_head;
  logic [1:0]        sel_idx;

  assign addr_a[CH_FIR] = fir_addr;
  assign addr_a[CH_QS]  = qs_addr;
  assign addr_a[CH_MM]  = mm_addr;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    prefetch_chan_ctrl #(
      .ADDR_W      (ADDR_W),
      .BURST_LEN   (BURST_LEN),
      .PREFETCH_EN (PREFETCH_EN)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_i       (req[c]),
      .addr_i      (addr_a[c]),
      .gnt_i       (pick[c]),
      .ack_i       (f_ack[c]),
      .wait_o      (wait_v[c]),
      .last_o      (last_v[c]),
      .hit_o       (hit_v[c]),
      .rsp_o       (rsp_v[c]),
      .head_o      (head_a[c]),
      .mis_index_o (idx_a[c]),
      .full_o      (full_v[c]),
      .empty_o     (empty_v[c])
    );
  end

  assign pick = (arb_q == ARB_IDLE) ? rr_pick(last_q, wait_v) : '0;

  always_comb begin
    sel_head = head_a[CH_MM];
    sel_idx  = 2'(CH_MM);
    if (pick[CH_QS]) begin
      sel_head = head_a[CH_QS];
      sel_idx  = 2'(CH_QS);
    end
    if (pick[CH_FIR]) begin
      sel_head = head_a[CH_FIR];
      sel_idx  = 2'(CH_FIR);
    end
  end

  // Last grant starts at MM so the first rotation lands on FIR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_q     <= ARB_IDLE;
      gnt_q     <= '0;
      sd_req_q  <= 1'b0;
      sd_addr_q <= '0;
      last_q    <= 2'(CH_MM);
    end else begin
      case (arb_q)
        ARB_IDLE: begin
          if (pick != '0) begin
            arb_q     <= ARB_BUSY;
            gnt_q     <= pick;
            sd_req_q  <= 1'b1;
            sd_addr_q <= sel_head;
            last_q    <= sel_idx;
          end
        end
        ARB_BUSY: begin
          if (last_v != '0) begin
            arb_q    <= ARB_IDLE;
            gnt_q    <= '0;
            sd_req_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign f_ack         = {NUM_CH{sd_ack}} & gnt_q;
  assign burst_req     = gnt_q;
  assign sd_req        = sd_req_q;
  assign sd_addr       = sd_addr_q;
  assign HIT           = hit_v;
  assign rsp_valid     = rsp_v;
  assign mis_index_FIR = idx_a[CH_FIR];
  assign mis_index_QS  = idx_a[CH_QS];
  assign mis_index_MM  = idx_a[CH_MM];
  assign state_reg     = {full_v[CH_FIR], empty_v[CH_FIR],
                          full_v[CH_QS],  empty_v[CH_QS],
                          full_v[CH_MM],  empty_v[CH_MM]};

endmodule

// File: tb/tb_prefetch_ctrl.sv
// Directed bench for prefetch_ctrl: fill, hits, speculative refill, RR
// arbitration, flush on mismatch and asynchronous reset mid-burst.
module tb_prefetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req;
  logic [31:0] fir_addr, qs_addr, mm_addr;
  logic [2:0]  rsp_valid;
  logic        sd_req;
  logic [31:0] sd_addr;
  logic        sd_ack;
  logic [2:0]  burst_req, f_ack, HIT;
  logic [3:0]  mis_index_FIR, mis_index_QS, mis_index_MM;
  logic [5:0]  state_reg;

  int checks = 0;
  int errors = 0;

  prefetch_ctrl #(
    .ADDR_W      (32),
    .BURST_LEN   (8),
    .PREFETCH_EN (1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .fir_addr      (fir_addr),
    .qs_addr       (qs_addr),
    .mm_addr       (mm_addr),
    .rsp_valid     (rsp_valid),
    .sd_req        (sd_req),
    .sd_addr       (sd_addr),
    .sd_ack        (sd_ack),
    .burst_req     (burst_req),
    .f_ack         (f_ack),
    .HIT           (HIT),
    .mis_index_FIR (mis_index_FIR),
    .mis_index_QS  (mis_index_QS),
    .mis_index_MM  (mis_index_MM),
    .state_reg     (state_reg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  initial begin
    rst_n = 1'b0; req = '0; sd_ack = 1'b0;
    fir_addr = '0; qs_addr = '0; mm_addr = '0;
    #12;
    chk("rst_state_reg", 64'(state_reg), 64'h15);
    chk("rst_sd_req", 64'(sd_req), 64'h0);
    chk("rst_burst_req", 64'(burst_req), 64'h0);
    chk("rst_hit", 64'(HIT), 64'h0);
    chk("rst_rsp", 64'(rsp_valid), 64'h0);
    rst_n = 1'b1;
    tick();

    // FIR miss at 0x100, grant, 8-word fill; held req must not hit mid-fill
    req = 3'b100; fir_addr = 32'h100;
    tick();
    chk("miss_no_sdreq_yet", 64'(sd_req), 64'h0);
    tick();
    chk("gnt_sd_req", 64'(sd_req), 64'h1);
    chk("gnt_sd_addr", 64'(sd_addr), 64'h100);
    chk("gnt_burst_req", 64'(burst_req), 64'h4);
    sd_ack = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk("fill_mis_index", 64'(mis_index_FIR), 64'(i));
      chk("fill_f_ack", 64'(f_ack), 64'h4);
      chk("fill_no_hit", 64'(HIT), 64'h0);
      tick();
    end
    chk("fill_done_burst_req", 64'(burst_req), 64'h0);
    chk("fill_done_sd_req", 64'(sd_req), 64'h0);
    chk("fill_done_index", 64'(mis_index_FIR), 64'h0);
    chk("ack_without_grant", 64'(f_ack), 64'h0);
    sd_ack = 1'b0;
    chk("no_hit_at_fill_edge", 64'(HIT), 64'h0);
    tick();
    chk("hit_0x100", 64'(HIT), 64'h4);
    chk("hit_rsp_not_yet", 64'(rsp_valid), 64'h0);
    chk("full_after_fill", 64'(state_reg), 64'h25);
    tick();
    chk("hit_pulse_one_cycle", 64'(HIT), 64'h0);
    chk("rsp_0x100", 64'(rsp_valid), 64'h4);
    chk("not_full_after_hit", 64'(state_reg), 64'h05);
    req = '0;
    tick();
    chk("rsp_one_cycle", 64'(rsp_valid), 64'h0);

    // Sequential hits 0x104..0x11C; the last empties FIR and triggers refill
    for (int i = 1; i < 8; i++) begin
      req = 3'b100; fir_addr = 32'h100 + 32'(4 * i);
      tick();
      chk("seq_hit", 64'(HIT), 64'h4);
      chk("seq_no_sd_req", 64'(sd_req), 64'h0);
      tick();
      chk("seq_rsp", 64'(rsp_valid), 64'h4);
      req = '0;
      tick();
    end
    chk("prefetch_sd_req", 64'(sd_req), 64'h1);
    chk("prefetch_sd_addr", 64'(sd_addr), 64'h120);
    chk("prefetch_burst_req", 64'(burst_req), 64'h4);
    chk("fir_empty", 64'(state_reg), 64'h15);
    sd_ack = 1'b1;
    repeat (8) tick();
    sd_ack = 1'b0;
    chk("prefetch_done", 64'(burst_req), 64'h0);

    // FIR full at head 0x120; request 0x200 flushes and refills
    req = 3'b100; fir_addr = 32'h200;
    tick();
    chk("flush_full_lag", 64'(state_reg[5:4]), 64'h2);
    tick();
    chk("flush_empty", 64'(state_reg[5:4]), 64'h1);
    chk("flush_sd_addr", 64'(sd_addr), 64'h200);
    chk("flush_sd_req", 64'(sd_req), 64'h1);
    sd_ack = 1'b1;
    repeat (8) tick();
    sd_ack = 1'b0;
    tick();
    chk("flush_hit", 64'(HIT), 64'h4);
    tick();
    chk("flush_rsp", 64'(rsp_valid), 64'h4);
    req = '0;
    tick();

    // QS and MM miss together after FIR was last granted: QS first, then MM
    req = 3'b011; qs_addr = 32'h400; mm_addr = 32'h800;
    tick();
    tick();
    chk("rr_qs_first", 64'(burst_req), 64'h2);
    chk("rr_qs_addr", 64'(sd_addr), 64'h400);
    sd_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("rr_qs_onehot", 64'(burst_req), 64'h2);
      tick();
    end
    sd_ack = 1'b0;
    chk("rr_gap", 64'(burst_req), 64'h0);
    tick();
    chk("rr_mm_next", 64'(burst_req), 64'h1);
    chk("rr_mm_addr", 64'(sd_addr), 64'h800);
    chk("rr_qs_hit", 64'(HIT), 64'h2);
    tick();
    chk("rr_qs_rsp", 64'(rsp_valid), 64'h2);
    req = 3'b001;
    sd_ack = 1'b1;
    repeat (8) tick();
    sd_ack = 1'b0;
    tick();
    chk("rr_mm_hit", 64'(HIT), 64'h1);
    tick();
    chk("rr_mm_rsp", 64'(rsp_valid), 64'h1);
    req = '0;
    tick();

    // Asynchronous reset after 3 acks of a FIR burst
    req = 3'b100; fir_addr = 32'h300;
    tick();
    tick();
    chk("rst_burst_started", 64'(burst_req), 64'h4);
    sd_ack = 1'b1;
    repeat (3) tick();
    sd_ack = 1'b0;
    chk("rst_index_3", 64'(mis_index_FIR), 64'h3);
    rst_n = 1'b0;
    #1;
    chk("async_burst_req", 64'(burst_req), 64'h0);
    chk("async_sd_req", 64'(sd_req), 64'h0);
    chk("async_hit", 64'(HIT), 64'h0);
    chk("async_index", 64'(mis_index_FIR), 64'h0);
    chk("async_state_reg", 64'(state_reg), 64'h15);
    sd_ack = 1'b1;
    #1;
    chk("async_f_ack", 64'(f_ack), 64'h0);
    req = '0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_f_ack", 64'(f_ack), 64'h0);
    chk("post_rst_sd_req", 64'(sd_req), 64'h0);
    sd_ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prefetch_ctrl.md
Name: prefetch_ctrl

Overview:
Controller that sequences the three-channel (FIR, QS, MM) 8-entry prefetch buffer. It tracks per-channel buffer contents and detects hit/miss for client read requests. On a miss it arbitrates the single SDRAM port round-robin and drives the burst fill, then serves hits. It generates burst_req, f_ack, HIT, the fill indices and the 6-bit state_reg that the buffer consumes. It sits between the user-project client masters, the SDRAM controller and the prefetch buffer.

Parameters:
ADDR_W, 32, byte address width
BURST_LEN, 8, words per burst; must be ≤ buffer depth 8
PREFETCH_EN, 1, on hit that empties a channel, speculatively refill from next address

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req  in  3  per-client read request [2]=FIR [1]=QS [0]=MM; held until rsp_valid
fir_addr  in  ADDR_W  FIR word address, stable while req[2]
qs_addr  in  ADDR_W  QS word address, stable while req[1]
mm_addr  in  ADDR_W  MM word address, stable while req[0]
rsp_valid  out  3  per-client one-cycle pulse; buffer data_out valid this cycle
sd_req  out  1  SDRAM burst request, held until last ack
sd_addr  out  ADDR_W  burst start address
sd_ack  in  1  one pulse per returned word
burst_req  out  3  per-channel fill active
f_ack  out  3  {3{sd_ack}} & burst_req (combinational)
HIT  out  3  per-channel one-cycle consume pulse
mis_index_FIR / mis_index_QS / mis_index_MM  out  4 each  fill write index
state_reg  out  6  {FIR full, FIR empty, QS full, QS empty, MM full, MM empty}

Behaviour:
- Reset (async, rst_n=0): all outputs 0 except state_reg=6'b010101; counts 0; RR pointer selects FIR first; sd_ack ignored while no grant.
- Per channel: head_addr (ADDR_W), count 0..8, state IDLE/WAIT_GNT/FILL/RESP.
- Hit: IDLE & req & count>0 & addr==head_addr → next cycle HIT=1 (one cycle), count−1, head_addr+4, go RESP; next cycle rsp_valid=1, back to IDLE. Hit latency: req sample N, HIT N+1, rsp_valid N+2.
- Miss: IDLE & req & (count==0 | addr!=head_addr) → count:=0 (flush), head_addr:=addr, WAIT_GNT.
- Arbiter states ARB_IDLE/ARB_BUSY. In ARB_IDLE, choose among WAIT_GNT channels round-robin starting after last grant; registered: burst_req[c]=1, sd_req=1, sd_addr=head_addr, channel→FILL, ARB_BUSY. Grant never changes in ARB_BUSY.
- FILL: each sd_ack: mis_index++, count++. On BURST_LEN-th ack: burst_req, sd_req, mis_index clear at that edge; channel → IDLE, which re-evaluates req as hit.
- HIT[c] never asserted while burst_req[c]=1.
- Speculative prefetch: PREFETCH_EN & HIT drives count to 0 → channel enters WAIT_GNT with head_addr already advanced; rsp_valid still issued normally.
- Full = count==8, empty = count==0; state_reg registered, updates cycle after count change.
- Simultaneous miss on 2–3 channels: one grant per burst, RR order. req deasserted in WAIT_GNT: burst still performed.
- Address width: head_addr+4 wraps modulo 2^ADDR_W.

Decomposition:
- Package prefetch_pkg: channel indices FIR=2/QS=1/MM=0, channel state enum, arbiter state enum, DEPTH=8, WORD_BYTES=4.
- Sub-module prefetch_chan_ctrl (instantiated ×3): hit/miss, count, head_addr, fill index, full/empty. Top holds arbiter and SDRAM mux.

Test Plan:
- Reset, FIR req addr 0x100 → WAIT_GNT, sd_req=1 sd_addr=0x100, 8 sd_ack, mis_index_FIR 0..7; then HIT[2] pulse, rsp_valid[2] 1 cycle later, state_reg[5]=0 after one hit.
- After fill at 0x100, FIR reads 0x104..0x11C → 7 HITs, no sd_req; 8th hit empties and, with PREFETCH_EN=1, sd_addr=0x120.
- QS and MM miss same cycle after last grant FIR → QS granted first, MM burst starts cycle after QS last ack; burst_req never two-hot.
- FIR holding 8 words, req 0x200 (mismatch) → flush, state_reg[4]=1, burst at 0x200.
- rst_n low mid-burst (after 3 acks) → burst_req, sd_req, HIT 0 immediately; further sd_ack produce f_ack=0.
- sd_ack during FIR fill while FIR req matches head → no HIT until fill complete.
